// File: rtl/pep_mmacc_gram_arb_nreq_if.sv
// Windowed GRAM request bundle for the mono-mult-acc slot arbiter.
// One target GRAM, critical flag and valid/ready pair per requester.
interface pep_mmacc_gram_arb_nreq_if #(
  parameter int GRAM_NB = 4,
  parameter int REQ_NB  = 2
);
  localparam int GW = (GRAM_NB > 1) ? $clog2(GRAM_NB) : 1;

  logic [REQ_NB*GW-1:0] req_grid;
  logic [REQ_NB-1:0]    req_critical;
  logic [REQ_NB-1:0]    req_vld;
  logic [REQ_NB-1:0]    req_rdy;

  modport master (
    output req_grid,
    output req_critical,
    output req_vld,
    input  req_rdy
  );

  modport slave (
    input  req_grid,
    input  req_critical,
    input  req_vld,
    output req_rdy
  );
endinterface

// File: rtl/pep_mmacc_gram_arb_nreq.sv
// GRAM slot arbiter: windowed A/B port ownership, background users on idle ports.
// Optional starvation promotion: PEP_MMACC_GRAM_ARB_AGE_PROMOTE_EN.
module pep_mmacc_gram_arb_nreq #(
  parameter int          GRAM_NB       = 4,
  parameter int          REQ_NB        = 2,
  parameter int          SLOT_CYCLE    = 4,
  parameter int          GLWE_SLOT_NB  = 2,
  parameter logic [31:0] ADD_SLOT_LIST = 32'h0000_0011,
  parameter int          AGE_SLOT_NB   = 8
) (
  input  logic                      clk,
  input  logic                      s_rst_n,
  pep_mmacc_gram_arb_nreq_if.slave  req,
  output logic [REQ_NB-1:0]         grant,
  output logic [REQ_NB*GRAM_NB-1:0] avail_a_1h,
  output logic [REQ_NB*GRAM_NB-1:0] avail_b,
  output logic [GRAM_NB-1:0]        bg_a_avail,
  output logic [GRAM_NB-1:0]        bg_b_avail
);
  localparam int GW = (GRAM_NB > 1) ? $clog2(GRAM_NB) : 1;
  localparam int RW = (REQ_NB > 1) ? $clog2(REQ_NB) : 1;
  localparam int CW = $clog2(GLWE_SLOT_NB + 16);
  localparam int SW = $clog2(SLOT_CYCLE);

  if (REQ_NB < 1 || REQ_NB > 8 || GRAM_NB < 1 || SLOT_CYCLE < 2 ||
      GLWE_SLOT_NB < 1 || AGE_SLOT_NB < 1) begin : g_bad_param
    $fatal(1, "pep_mmacc_gram_arb_nreq: bad parameter");
  end

  logic [SW-1:0] slot_cnt;
  logic          boundary;
  logic [RW-1:0] rr;
  logic [RW-1:0] rr_nx;
  logic [RW-1:0] last;
  logic          hit;

  logic [CW-1:0] a_rem   [GRAM_NB];
  logic [CW-1:0] b_rem   [GRAM_NB];
  logic [CW-1:0] a_dec   [GRAM_NB];
  logic [CW-1:0] b_dec   [GRAM_NB];
  logic [CW-1:0] a_nx    [GRAM_NB];
  logic [CW-1:0] b_nx    [GRAM_NB];
  logic [RW-1:0] owner_a [GRAM_NB];
  logic [RW-1:0] owner_b [GRAM_NB];
  logic [RW-1:0] oa_nx   [GRAM_NB];
  logic [RW-1:0] ob_nx   [GRAM_NB];

  logic [GRAM_NB-1:0]        free;
  logic [GRAM_NB-1:0]        taken;
  logic [REQ_NB-1:0]         hold_a;
  logic [REQ_NB-1:0]         sel;
  logic [REQ_NB-1:0]         acc;
  logic [REQ_NB-1:0]         prio;
  logic [REQ_NB*GRAM_NB-1:0] aa_nx;
  logic [REQ_NB*GRAM_NB-1:0] ab_nx;
  logic [GRAM_NB-1:0]        bga_nx;
  logic [GRAM_NB-1:0]        bgb_nx;

  assign boundary = (slot_cnt == SW'(SLOT_CYCLE - 1));
  assign acc = {REQ_NB{boundary & s_rst_n}} & sel;
  assign req.req_rdy = acc;
  assign rr_nx = (last == RW'(REQ_NB - 1)) ? '0 : last + 1'b1;

`ifdef PEP_MMACC_GRAM_ARB_AGE_PROMOTE_EN
  localparam int AW = $clog2(AGE_SLOT_NB + 1);
  logic [AW-1:0] age [REQ_NB];

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      for (int i = 0; i < REQ_NB; i++) age[i] <= '0;
    end else if (boundary) begin
      for (int i = 0; i < REQ_NB; i++) begin
        if (acc[i]) age[i] <= '0;
        else if (req.req_vld[i] && age[i] != AW'(AGE_SLOT_NB))
          age[i] <= age[i] + 1'b1;
      end
    end
  end

  always_comb begin
    prio = '0;
    for (int i = 0; i < REQ_NB; i++)
      prio[i] = req.req_critical[i] | (age[i] >= AW'(AGE_SLOT_NB));
  end
`else
  assign prio = req.req_critical;
`endif

  always_comb begin
    free = '0;
    for (int g = 0; g < GRAM_NB; g++) begin
      a_dec[g] = (a_rem[g] == '0) ? '0 : a_rem[g] - 1'b1;
      b_dec[g] = (b_rem[g] == '0) ? '0 : b_rem[g] - 1'b1;
      free[g]  = (a_dec[g] == '0) && (b_dec[g] == '0);
    end
  end

  // A requester still inside an A window cannot open a second one.
  always_comb begin
    hold_a = '0;
    for (int i = 0; i < REQ_NB; i++)
      for (int g = 0; g < GRAM_NB; g++)
        if (owner_a[g] == RW'(i) && a_dec[g] != '0) hold_a[i] = 1'b1;
  end

  // h=0/1: critical from rr then wrapped; h=2/3: same for non-critical.
  always_comb begin
    sel   = '0;
    taken = '0;
    last  = '0;
    hit   = 1'b0;
    for (int h = 0; h < 4; h++)
      for (int i = 0; i < REQ_NB; i++)
        if (req.req_vld[i] && (prio[i] == (h < 2)) &&
            ((h % 2 == 0) == (i >= int'(rr))) && !hold_a[i])
          for (int g = 0; g < GRAM_NB; g++)
            if (req.req_grid[i*GW +: GW] == GW'(g) &&
                free[g] && !taken[g]) begin
              sel[i]   = 1'b1;
              taken[g] = 1'b1;
              last     = RW'(i);
              hit      = 1'b1;
            end
  end

  always_comb begin
    for (int g = 0; g < GRAM_NB; g++) begin
      a_nx[g]  = boundary ? a_dec[g] : a_rem[g];
      b_nx[g]  = boundary ? b_dec[g] : b_rem[g];
      oa_nx[g] = owner_a[g];
      ob_nx[g] = owner_b[g];
    end
    for (int i = 0; i < REQ_NB; i++)
      for (int g = 0; g < GRAM_NB; g++)
        if (acc[i] && req.req_grid[i*GW +: GW] == GW'(g)) begin
          a_nx[g]  = CW'(GLWE_SLOT_NB);
          b_nx[g]  = CW'(GLWE_SLOT_NB) + CW'(ADD_SLOT_LIST[4*i +: 4]);
          oa_nx[g] = RW'(i);
          ob_nx[g] = RW'(i);
        end
    aa_nx  = '0;
    ab_nx  = '0;
    bga_nx = '0;
    bgb_nx = '0;
    for (int g = 0; g < GRAM_NB; g++) begin
      bga_nx[g] = (a_nx[g] == '0);
      bgb_nx[g] = (b_nx[g] == '0);
      for (int i = 0; i < REQ_NB; i++) begin
        if (a_nx[g] != '0 && oa_nx[g] == RW'(i))
          aa_nx[i*GRAM_NB + g] = 1'b1;
        if (b_nx[g] != '0 && ob_nx[g] == RW'(i))
          ab_nx[i*GRAM_NB + g] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      slot_cnt   <= '0;
      rr         <= '0;
      grant      <= '0;
      avail_a_1h <= '0;
      avail_b    <= '0;
      bg_a_avail <= '0;
      bg_b_avail <= '0;
      for (int g = 0; g < GRAM_NB; g++) begin
        a_rem[g]   <= '0;
        b_rem[g]   <= '0;
        owner_a[g] <= '0;
        owner_b[g] <= '0;
      end
    end else begin
      slot_cnt <= boundary ? '0 : slot_cnt + 1'b1;
      if (boundary && hit) rr <= rr_nx;
      grant      <= acc;
      avail_a_1h <= aa_nx;
      avail_b    <= ab_nx;
      bg_a_avail <= bga_nx;
      bg_b_avail <= bgb_nx;
      for (int g = 0; g < GRAM_NB; g++) begin
        a_rem[g]   <= a_nx[g];
        b_rem[g]   <= b_nx[g];
        owner_a[g] <= oa_nx[g];
        owner_b[g] <= ob_nx[g];
      end
    end
  end
endmodule
